// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// The state enum, the grant encoding and the counter sizing all live here.
package mem_arb_pkg;

  localparam int MEM_LAT_MAX = 4;
  localparam int CNT_W       = $clog2(MEM_LAT_MAX);

  localparam logic GRANT_IF = 1'b0;
  localparam logic GRANT_DM = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } arb_state_e;

endpackage

// File: rtl/mem_arb_pick.sv
// Combinational round-robin selector between the fetch and data ports.
// On contention the port that was not granted last time wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
  input  logic last_grant,
  output logic valid,
  output logic grant
);

  always_comb begin
    valid = if_req | dm_req;
    grant = GRANT_IF;
    if (if_req && dm_req) begin
      grant = ~last_grant;
    end else if (dm_req) begin
      grant = GRANT_DM;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises fetch and load/store accesses onto the single-ported memory.
// One transaction at a time: grant, one ACCESS strobe, MEM_LAT wait, ack.
//
// state  | meaning
// IDLE   | no transaction; requests are sampled and a winner is latched
// ACCESS | mem_en strobe with the latched address/data/we; counter loaded
// WAIT   | counting down the read latency; rdata captured at count 0
// DONE   | ack pulse to the granted port; requests are ignored
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic              dm_ack,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              grant_q, grant_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;

  logic pick_valid;
  logic pick_grant;

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .last_grant (last_grant_q),
    .valid      (pick_valid),
    .grant      (pick_grant)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      grant_q      <= GRANT_IF;
      last_grant_q <= GRANT_IF;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      if_rdata_q   <= '0;
      dm_rdata_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      if_rdata_q   <= if_rdata_d;
      dm_rdata_q   <= dm_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    if_rdata_d   = if_rdata_q;
    dm_rdata_d   = dm_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (pick_valid) begin
          grant_d      = pick_grant;
          last_grant_d = pick_grant;
          state_d      = ACCESS;
          if (pick_grant == GRANT_DM) begin
            addr_d  = dm_addr;
            we_d    = dm_we;
            wdata_d = dm_wdata;
          end else begin
            // fetches never write; the write-data pins keep their old value
            addr_d = if_addr;
            we_d   = 1'b0;
          end
        end
      end
      ACCESS: begin
        cnt_d   = CNT_W'(MEM_LAT - 1);
        state_d = WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = DONE;
          if (!we_q) begin
            if (grant_q == GRANT_DM) begin
              dm_rdata_d = mem_rdata;
            end else begin
              if_rdata_d = mem_rdata;
            end
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign if_ack    = (state_q == DONE) && (grant_q == GRANT_IF);
  assign dm_ack    = (state_q == DONE) && (grant_q == GRANT_DM);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;
  assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: four instances with MEM_LAT = 1..4, each with its own memory.
// A transaction-timeline model predicts every output each cycle; directed tests add literal checks.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst      [NI];
  logic        if_req   [NI];
  logic [31:0] if_addr  [NI];
  logic        if_ack   [NI];
  logic [31:0] if_rdata [NI];
  logic        dm_req   [NI];
  logic        dm_we    [NI];
  logic [31:0] dm_addr  [NI];
  logic [31:0] dm_wdata [NI];
  logic        dm_ack   [NI];
  logic [31:0] dm_rdata [NI];
  logic        mem_en   [NI];
  logic        mem_we   [NI];
  logic [31:0] mem_addr [NI];
  logic [31:0] mem_wdata[NI];
  logic [31:0] mem_rdata[NI];
  logic        busy     [NI];

  int pass_cnt  = 0;
  int total_cnt = 0;
  int cyc       = 0;
  bit chk_on    = 1'b0;
  int en_cnt [NI];
  int we_cnt [NI];
  int ack_cnt[NI];

  function automatic logic [31:0] init_word(int idx);
    if (idx == 16) return 32'h2008_0005;
    return 32'h5A00_0000 + (32'(idx) * 32'h0001_0203);
  endfunction

  // ---------------- DUTs and memory stubs ----------------
  for (genvar g = 0; g < NI; g++) begin : g_inst
    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(g + 1)) u_dut (
      .clk(clk), .reset(rst[g]),
      .if_req(if_req[g]), .if_addr(if_addr[g]), .if_ack(if_ack[g]), .if_rdata(if_rdata[g]),
      .dm_req(dm_req[g]), .dm_we(dm_we[g]), .dm_addr(dm_addr[g]), .dm_wdata(dm_wdata[g]),
      .dm_ack(dm_ack[g]), .dm_rdata(dm_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]), .mem_addr(mem_addr[g]),
      .mem_wdata(mem_wdata[g]), .mem_rdata(mem_rdata[g]), .busy(busy[g])
    );

    logic [31:0] mem  [256];
    bit          wrt  [256];
    logic [31:0] pipe [g + 1];

    always @(posedge clk) begin
      if (mem_en[g] === 1'b1 && mem_we[g] === 1'b1) begin
        mem[mem_addr[g][9:2]] <= mem_wdata[g];
        wrt[mem_addr[g][9:2]] <= 1'b1;
      end
      if (mem_en[g] === 1'b1 && mem_we[g] === 1'b0)
        pipe[0] <= wrt[mem_addr[g][9:2]] ? mem[mem_addr[g][9:2]]
                                        : init_word(int'(mem_addr[g][9:2]));
      else
        pipe[0] <= 32'hBADC_0FFE;
      for (int k = 1; k <= g; k++) pipe[k] <= pipe[k - 1];
    end
    assign mem_rdata[g] = pipe[g];
  end

  // ---------------- transaction-timeline model ----------------
  bit          mb    [NI];
  int          acc_c [NI];
  int          ack_c [NI];
  bit          mg    [NI];
  bit          mlast [NI];
  bit          mwe   [NI];
  logic [31:0] maddr [NI];
  logic [31:0] mwdata[NI];
  logic [31:0] mval  [NI];
  logic [31:0] mif_rd[NI];
  logic [31:0] mdm_rd[NI];
  logic [31:0] sh    [NI][256];
  bit          shw   [NI][256];

  function automatic logic [31:0] rd_model(int i, logic [31:0] a);
    return shw[i][a[9:2]] ? sh[i][a[9:2]] : init_word(int'(a[9:2]));
  endfunction

  function automatic bit pick_model(logic ifr, logic dmr, bit last);
    if (ifr && dmr) return !last;
    return dmr;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NI; i++) begin
      if (mb[i] && cyc == acc_c[i] && mwe[i]) begin
        sh[i][maddr[i][9:2]]  <= mwdata[i];
        shw[i][maddr[i][9:2]] <= 1'b1;
      end
      if (rst[i]) begin
        mb[i]     <= 1'b0;
        mlast[i]  <= GRANT_IF;
        mif_rd[i] <= '0;
        mdm_rd[i] <= '0;
      end else if (mb[i]) begin
        if (cyc == acc_c[i]) mval[i] <= rd_model(i, maddr[i]);
        if (cyc == ack_c[i] - 1 && !mwe[i]) begin
          if (mg[i] == GRANT_DM) mdm_rd[i] <= mval[i];
          else                   mif_rd[i] <= mval[i];
        end
        if (cyc == ack_c[i]) mb[i] <= 1'b0;
      end else if (if_req[i] || dm_req[i]) begin
        mb[i]     <= 1'b1;
        mg[i]     <= pick_model(if_req[i], dm_req[i], mlast[i]);
        mlast[i]  <= pick_model(if_req[i], dm_req[i], mlast[i]);
        acc_c[i]  <= cyc + 1;
        ack_c[i]  <= cyc + (i + 1) + 2;
        maddr[i]  <= pick_model(if_req[i], dm_req[i], mlast[i]) ? dm_addr[i] : if_addr[i];
        mwe[i]    <= pick_model(if_req[i], dm_req[i], mlast[i]) ? dm_we[i] : 1'b0;
        mwdata[i] <= dm_wdata[i];
      end
    end
    cyc <= cyc + 1;
  end

  // ---------------- checking ----------------
  task automatic chk(string nm, int i, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s inst%0d cyc%0d: got %h expected %h", nm, i, cyc, act, exp);
  endtask

  task automatic tick();
    @(negedge clk);
    if (chk_on) begin
      for (int i = 0; i < NI; i++) begin
        bit e_en;
        e_en = mb[i] && (cyc == acc_c[i]);
        chk("mem_en",   i, 32'(mem_en[i]), 32'(e_en));
        chk("mem_we",   i, 32'(mem_we[i]), 32'(e_en && mwe[i]));
        chk("if_ack",   i, 32'(if_ack[i]), 32'(mb[i] && cyc == ack_c[i] && mg[i] == GRANT_IF));
        chk("dm_ack",   i, 32'(dm_ack[i]), 32'(mb[i] && cyc == ack_c[i] && mg[i] == GRANT_DM));
        chk("busy",     i, 32'(busy[i]),   32'(mb[i]));
        chk("if_rdata", i, if_rdata[i], mif_rd[i]);
        chk("dm_rdata", i, dm_rdata[i], mdm_rd[i]);
        if (e_en) begin
          chk("mem_addr", i, mem_addr[i], maddr[i]);
          if (mwe[i]) chk("mem_wdata", i, mem_wdata[i], mwdata[i]);
        end
        if (mem_en[i] === 1'b1) en_cnt[i]++;
        if (mem_we[i] === 1'b1) we_cnt[i]++;
        if (dm_ack[i] === 1'b1 || if_ack[i] === 1'b1) ack_cnt[i]++;
      end
    end
  endtask

  task automatic wait_ack(int i, bit dm, int budget, output int c);
    bit seen;
    seen = 1'b0;
    c = -1;
    for (int k = 0; k < budget && !seen; k++) begin
      tick();
      if ((dm ? dm_ack[i] : if_ack[i]) === 1'b1) begin
        seen = 1'b1;
        c = cyc;
      end
    end
    if (!seen) chk("ack_timeout", i, 32'd0, 32'd1);
  endtask

  // issue one request, hold it until ack, drop it in the ack cycle; returns latency
  task automatic do_req(int i, bit dm, bit we, logic [31:0] a, logic [31:0] wd, output int lat);
    int c0, c;
    c0 = cyc;
    if (dm) begin
      dm_we[i] = we; dm_addr[i] = a; dm_wdata[i] = wd; dm_req[i] = 1'b1;
    end else begin
      if_addr[i] = a; if_req[i] = 1'b1;
    end
    wait_ack(i, dm, 20, c);
    if_req[i] = 1'b0;
    dm_req[i] = 1'b0;
    lat = c - c0;
  endtask

  initial begin
    int lat, e0, w0, a0, c0, nack;
    bit   ports[4];
    int   acyc[4];

    for (int i = 0; i < NI; i++) begin
      rst[i] = 1'b1; if_req[i] = 1'b0; dm_req[i] = 1'b0; dm_we[i] = 1'b0;
      if_addr[i] = '0; dm_addr[i] = '0; dm_wdata[i] = '0;
      en_cnt[i] = 0; we_cnt[i] = 0; ack_cnt[i] = 0;
    end
    repeat (3) tick();
    for (int i = 0; i < NI; i++) rst[i] = 1'b0;
    chk_on = 1'b1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_mem_addr",  i, mem_addr[i], 32'h0);
      chk("rst_mem_wdata", i, mem_wdata[i], 32'h0);
      chk("rst_busy",      i, 32'(busy[i]), 32'h0);
    end
    tick();

    // single fetch, MEM_LAT=1
    e0 = en_cnt[0];
    do_req(0, 1'b0, 1'b0, 32'h0000_0040, 32'h0, lat);
    chk("fetch_lat",   0, 32'(lat), 32'd3);
    chk("fetch_rdata", 0, if_rdata[0], 32'h2008_0005);
    chk("fetch_dm",    0, dm_rdata[0], 32'h0);
    repeat (3) tick();
    chk("fetch_en_cnt", 0, 32'(en_cnt[0] - e0), 32'd1);

    // store then load, MEM_LAT=2
    w0 = we_cnt[1];
    do_req(1, 1'b1, 1'b1, 32'h0000_0100, 32'hDEAD_BEEF, lat);
    chk("store_lat",   1, 32'(lat), 32'd4);
    chk("store_rdata", 1, dm_rdata[1], 32'h0);
    chk("store_we",    1, 32'(we_cnt[1] - w0), 32'd1);
    tick();
    do_req(1, 1'b1, 1'b0, 32'h0000_0100, 32'h0, lat);
    chk("load_lat",   1, 32'(lat), 32'd4);
    chk("load_rdata", 1, dm_rdata[1], 32'hDEAD_BEEF);
    repeat (3) tick();

    // contention from reset release, MEM_LAT=3
    rst[2] = 1'b1;
    tick();
    if_addr[2] = 32'h40; dm_addr[2] = 32'h104; dm_we[2] = 1'b0;
    if_req[2] = 1'b1; dm_req[2] = 1'b1; rst[2] = 1'b0;
    c0 = cyc;
    nack = 0;
    for (int k = 0; k < 60 && nack < 4; k++) begin
      tick();
      if (if_ack[2] === 1'b1 || dm_ack[2] === 1'b1) begin
        ports[nack] = (dm_ack[2] === 1'b1);
        acyc[nack]  = cyc;
        nack++;
      end
    end
    if_req[2] = 1'b0; dm_req[2] = 1'b0;
    chk("rr_count", 2, 32'(nack), 32'd4);
    if (nack == 4) begin
      chk("rr_first_cyc", 2, 32'(acyc[0] - c0), 32'd5);
      for (int k = 0; k < 4; k++) begin
        chk("rr_order", 2, 32'(ports[k]), 32'(k % 2 == 0));
        if (k > 0) chk("rr_spacing", 2, 32'(acyc[k] - acyc[k - 1]), 32'd6);
      end
    end
    chk("rr_if_rdata", 2, if_rdata[2], 32'h2008_0005);
    chk("rr_dm_rdata", 2, dm_rdata[2], init_word(65));
    repeat (3) tick();

    // latency sweep over all four instances
    for (int i = 0; i < NI; i++) begin
      do_req(i, 1'b1, 1'b0, 32'h0000_0040, 32'h0, lat);
      chk("sweep_lat",   i, 32'(lat), 32'(i + 3));
      chk("sweep_rdata", i, dm_rdata[i], 32'h2008_0005);
      repeat (2) tick();
    end

    // reset in WAIT of a load, MEM_LAT=4
    a0 = ack_cnt[3];
    dm_we[3] = 1'b0; dm_addr[3] = 32'h104; dm_req[3] = 1'b1;
    tick();
    tick();
    rst[3] = 1'b1; dm_req[3] = 1'b0;
    tick();
    rst[3] = 1'b0;
    chk("rstw_busy",  3, 32'(busy[3]), 32'h0);
    chk("rstw_ack",   3, 32'(dm_ack[3]), 32'h0);
    chk("rstw_rdata", 3, dm_rdata[3], 32'h0);
    repeat (8) tick();
    chk("rstw_no_ack", 3, 32'(ack_cnt[3] - a0), 32'd0);
    do_req(3, 1'b1, 1'b0, 32'h0000_0040, 32'h0, lat);
    chk("rstw_next_lat",   3, 32'(lat), 32'd6);
    chk("rstw_next_rdata", 3, dm_rdata[3], 32'h2008_0005);
    repeat (3) tick();

    // dm_req dropped one cycle after grant, MEM_LAT=2
    e0 = en_cnt[1];
    a0 = ack_cnt[1];
    c0 = cyc;
    dm_we[1] = 1'b0; dm_addr[1] = 32'h100; dm_req[1] = 1'b1;
    tick();
    dm_req[1] = 1'b0;
    wait_ack(1, 1'b1, 20, lat);
    chk("drop_lat",   1, 32'(lat - c0), 32'd4);
    chk("drop_rdata", 1, dm_rdata[1], 32'hDEAD_BEEF);
    repeat (6) tick();
    chk("drop_en_cnt",  1, 32'(en_cnt[1] - e0), 32'd1);
    chk("drop_ack_cnt", 1, 32'(ack_cnt[1] - a0), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
